ac_e_unit: RTL and testbench
============================

AC_E_UNIT -- requirements
Module: ac_e_unit

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the accumulator width; legal range 4..32.
REQ-002 Parameter INC_SETS_E, default 0, SHALL select whether INC writes its carry-out into E (1) or leaves E unchanged (0).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 en  input  1  SHALL be the operation enable; when it is 0 the unit holds all state.
REQ-006 op  input  4  SHALL select the operation; encoding per REQ-012.
REQ-007 din  input  WIDTH  SHALL be the data operand for LD/ADD/AND.
REQ-008 ac_out  output  WIDTH  SHALL be the registered accumulator value.
REQ-009 e_out  output  1  SHALL be the registered E (extend) flip-flop.
REQ-010 ac_zero  output  1  SHALL be 1 exactly when ac_out is all zeros (combinational from register).
REQ-011 ac_neg  output  1  SHALL equal ac_out[WIDTH-1].

Function
REQ-012 op encoding SHALL be: 0 NOP, 1 LD, 2 CLR, 3 INC, 4 CMA, 5 CLE, 6 CME, 7 CIR, 8 CIL, 9 ADD, 10 AND; codes 11-15 SHALL behave as NOP.
REQ-013 Every op SHALL complete in one cycle; the result SHALL be visible on ac_out/e_out the cycle after the enabling edge.
REQ-014 LD: AC <= din; E unchanged.
REQ-015 CLR: AC <= 0; E unchanged.
REQ-016 INC: AC <= AC+1 modulo 2^WIDTH; all-ones SHALL wrap to 0; E <= carry-out only if INC_SETS_E=1.
REQ-017 CMA: AC <= ~AC; E unchanged.
REQ-018 CLE: E <= 0; AC unchanged. CME: E <= ~E; AC unchanged.
REQ-019 CIR: {AC,E} <= {E, AC[WIDTH-1:1], AC[0]}; i.e. E enters MSB, AC[0] goes to E.
REQ-020 CIL: {E,AC} <= {AC[WIDTH-1], AC[WIDTH-2:0], E}; i.e. E enters LSB, MSB goes to E.
REQ-021 ADD: {E,AC} <= AC + din computed in WIDTH+1 bits; E SHALL receive the carry-out, previous E is not an input.
REQ-022 AND: AC <= AC & din; E unchanged.
REQ-023 With en=0, AC and E SHALL hold regardless of op and din.
REQ-024 ac_zero and ac_neg SHALL reflect the registered AC only, never the pending result.

Reset
REQ-025 On reset_n=0, AC SHALL be 0 and E SHALL be 0 immediately, independent of clk.
REQ-026 Reset SHALL override en and any op; after reset, ac_zero=1 and ac_neg=0.
REQ-027 Deassertion of reset_n SHALL be synchronised externally; the first enabled edge after deassertion executes normally.

Structure
REQ-028 Op codes (OP_NOP..OP_AND) and the default WIDTH SHALL live in shared package bc_pkg, used by the control unit and this block.
REQ-029 Next-state arithmetic SHALL be a combinational sub-module ac_alu (inputs AC, E, din, op; outputs next AC, next E); ac_e_unit SHALL contain only the registers, enable/reset and flag logic.

Verification
REQ-030 Reset mid-op: WIDTH=16, LD 0xBEEF, assert reset_n=0 between edges -> ac_out=0x0000, e_out=0 before next edge, ac_zero=1.
REQ-031 ADD carry: AC=0xFFFF, E=0, ADD din=0x0001 -> AC=0x0000, E=1, ac_zero=1; then ADD din=0x0001 -> AC=0x0001, E=0.
REQ-032 Circulate: AC=0x8001, E=0; CIR -> AC=0x4000, E=1; CIL -> AC=0x8001, E=0; CIL -> AC=0x0002, E=1.
REQ-033 INC wrap: INC_SETS_E=0, AC=0xFFFF, E=0, INC -> AC=0x0000, E=0; rerun with INC_SETS_E=1 -> E=1.
REQ-034 Hold/undefined: en=0 with op=LD din=0x1234 -> AC/E unchanged; en=1 op=13 -> unchanged; CMA on 0x00FF -> 0xFF00, ac_neg=1.
REQ-035 Width sweep: WIDTH=8 ADD 0xF0+0x20 -> AC=0x10, E=1; CME twice returns E to 1.

Source files
------------

// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
// Shared definitions for the basic-computer datapath blocks: the default
// accumulator width and the register-reference operation codes used by both
// the control unit and the AC/E unit.
// ---------------------------------------------------------------------------
package bc_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Operation codes; 11..15 are unassigned and act as NOP.
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LD  = 4'd1,
        OP_CLR = 4'd2,
        OP_INC = 4'd3,
        OP_CMA = 4'd4,
        OP_CLE = 4'd5,
        OP_CME = 4'd6,
        OP_CIR = 4'd7,
        OP_CIL = 4'd8,
        OP_ADD = 4'd9,
        OP_AND = 4'd10
    } op_e;

endpackage : bc_pkg

// File: rtl/ac_alu.sv
// ---------------------------------------------------------------------------
// ac_alu
// Purely combinational next-state logic for the accumulator (AC) and the
// extend flip-flop (E).
// Ports:
//   ac_i     [WIDTH-1:0]  current AC
//   e_i                   current E
//   din_i    [WIDTH-1:0]  data operand for LD/ADD/AND
//   op_i     [3:0]        operation code (bc_pkg::op_e encoding)
//   ac_nxt_o [WIDTH-1:0]  AC value after the operation
//   e_nxt_o               E value after the operation
// ---------------------------------------------------------------------------
module ac_alu
    import bc_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit INC_SETS_E = 1'b0
) (
    input  logic [WIDTH-1:0] ac_i,
    input  logic             e_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] ac_nxt_o,
    output logic             e_nxt_o
);

    // One extra bit holds the carry-out of the WIDTH-bit additions.
    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] inc_s;

    assign sum_s = {1'b0, ac_i} + {1'b0, din_i};
    assign inc_s = {1'b0, ac_i} + {{WIDTH{1'b0}}, 1'b1};

    // Next AC/E selection; unlisted codes fall through to hold.
    always_comb begin
        ac_nxt_o = ac_i;
        e_nxt_o  = e_i;
        case (op_i)
            OP_NOP: begin
                ac_nxt_o = ac_i;
                e_nxt_o  = e_i;
            end
            OP_LD:  ac_nxt_o = din_i;
            OP_CLR: ac_nxt_o = {WIDTH{1'b0}};
            OP_INC: begin
                ac_nxt_o = inc_s[WIDTH-1:0];
                if (INC_SETS_E) begin
                    e_nxt_o = inc_s[WIDTH];
                end else begin
                    e_nxt_o = e_i;
                end
            end
            OP_CMA: ac_nxt_o = ~ac_i;
            OP_CLE: e_nxt_o  = 1'b0;
            OP_CME: e_nxt_o  = ~e_i;
            // Rotate the (WIDTH+1)-bit ring {AC,E} right: E enters the MSB.
            OP_CIR: begin
                ac_nxt_o = {e_i, ac_i[WIDTH-1:1]};
                e_nxt_o  = ac_i[0];
            end
            // Rotate the ring {E,AC} left: E enters the LSB.
            OP_CIL: begin
                ac_nxt_o = {ac_i[WIDTH-2:0], e_i};
                e_nxt_o  = ac_i[WIDTH-1];
            end
            // Previous E is not an addend; it is replaced by the carry-out.
            OP_ADD: begin
                ac_nxt_o = sum_s[WIDTH-1:0];
                e_nxt_o  = sum_s[WIDTH];
            end
            OP_AND: ac_nxt_o = ac_i & din_i;
            default: begin
                ac_nxt_o = ac_i;
                e_nxt_o  = e_i;
            end
        endcase
    end

endmodule : ac_alu

// File: rtl/ac_e_unit.sv
// ---------------------------------------------------------------------------
// ac_e_unit
// Accumulator (AC) and extend flip-flop (E) of the basic computer. Holds the
// registers, the enable gating and the status flags; the operation itself is
// computed by ac_alu.
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset (clears AC and E)
//   en       operation enable; 0 holds AC and E
//   op [3:0] operation code (bc_pkg::op_e encoding)
//   din      data operand
//   ac_out   registered AC
//   e_out    registered E
//   ac_zero  1 when the registered AC is all zeros
//   ac_neg   MSB of the registered AC
// ---------------------------------------------------------------------------
module ac_e_unit
    import bc_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit INC_SETS_E = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] ac_out,
    output logic             e_out,
    output logic             ac_zero,
    output logic             ac_neg
);

    logic [WIDTH-1:0] ac_q;
    logic [WIDTH-1:0] ac_d;
    logic             e_q;
    logic             e_d;
    logic [WIDTH-1:0] alu_ac_s;
    logic             alu_e_s;

    ac_alu #(
        .WIDTH      (WIDTH),
        .INC_SETS_E (INC_SETS_E)
    ) u_alu (
        .ac_i     (ac_q),
        .e_i      (e_q),
        .din_i    (din),
        .op_i     (op),
        .ac_nxt_o (alu_ac_s),
        .e_nxt_o  (alu_e_s)
    );

    // Enable gating: take the ALU result only on enabled cycles.
    always_comb begin
        ac_d = ac_q;
        e_d  = e_q;
        if (en) begin
            ac_d = alu_ac_s;
            e_d  = alu_e_s;
        end else begin
            ac_d = ac_q;
            e_d  = e_q;
        end
    end

    // AC/E state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ac_q <= {WIDTH{1'b0}};
            e_q  <= 1'b0;
        end else begin
            ac_q <= ac_d;
            e_q  <= e_d;
        end
    end

    // Flags derive from the registered AC, never from the pending result.
    assign ac_out  = ac_q;
    assign e_out   = e_q;
    assign ac_zero = (ac_q == {WIDTH{1'b0}});
    assign ac_neg  = ac_q[WIDTH-1];

endmodule : ac_e_unit

// File: tb/tb_ac_e_unit.sv
// ---------------------------------------------------------------------------
// tb_ac_e_unit
// Three instances share one stimulus stream: 16-bit with INC leaving E,
// 16-bit with INC writing E, and 8-bit. A reference model written from the
// operation definitions predicts each instance; expectations are queued by
// the stimulus process and popped/compared by an independent monitor.
// ---------------------------------------------------------------------------
module tb_ac_e_unit;

    localparam int NDUT = 3;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [3:0]  op;
    logic [15:0] din;

    logic [15:0] ac_a, ac_b;
    logic [7:0]  ac_c;
    logic        e_a, e_b, e_c;
    logic        z_a, z_b, z_c;
    logic        n_a, n_b, n_c;

    ac_e_unit #(.WIDTH(16), .INC_SETS_E(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .en(en), .op(op), .din(din),
        .ac_out(ac_a), .e_out(e_a), .ac_zero(z_a), .ac_neg(n_a)
    );

    ac_e_unit #(.WIDTH(16), .INC_SETS_E(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .en(en), .op(op), .din(din),
        .ac_out(ac_b), .e_out(e_b), .ac_zero(z_b), .ac_neg(n_b)
    );

    ac_e_unit #(.WIDTH(8), .INC_SETS_E(1'b0)) dut_c (
        .clk(clk), .reset_n(reset_n), .en(en), .op(op), .din(din[7:0]),
        .ac_out(ac_c), .e_out(e_c), .ac_zero(z_c), .ac_neg(n_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NDUT-1:0][31:0] ac;
        logic [NDUT-1:0]       e;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state per instance.
    logic [31:0] m_ac [NDUT];
    logic        m_e  [NDUT];
    int          m_w  [NDUT] = '{16, 16, 8};
    bit          m_ise[NDUT] = '{1'b0, 1'b1, 1'b0};

    // Reference: the operation treated as arithmetic on a w-bit number.
    function automatic logic [32:0] ref_step(input logic [31:0] ac_in,
                                             input logic e_in, input int opc,
                                             input logic [31:0] d_in,
                                             input int w, input bit ise);
        longint mask, a, d, s;
        logic   e, nb;
        mask = (64'd1 << w) - 64'd1;
        a = longint'(ac_in) & mask;
        d = longint'(d_in) & mask;
        e = e_in;
        case (opc)
            1:  a = d;
            2:  a = 0;
            3:  begin
                    s = a + 1;
                    if (ise) e = s[w];
                    a = s & mask;
                end
            4:  a = (~a) & mask;
            5:  e = 1'b0;
            6:  e = ~e;
            7:  begin
                    nb = a[0];
                    a = (a >> 1) | (longint'(e) << (w - 1));
                    e = nb;
                end
            8:  begin
                    nb = a[w-1];
                    a = ((a << 1) | longint'(e)) & mask;
                    e = nb;
                end
            9:  begin
                    s = a + d;
                    e = s[w];
                    a = s & mask;
                end
            10: a = a & d;
            default: ;
        endcase
        return {e, a[31:0]};
    endfunction

    function automatic exp_t snapshot();
        exp_t x;
        for (int k = 0; k < NDUT; k++) begin
            x.ac[k] = m_ac[k];
            x.e[k]  = m_e[k];
        end
        return x;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NDUT; k++) begin
            m_ac[k] = 32'd0;
            m_e[k]  = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic apply(input logic en_i, input int opc, input logic [15:0] d);
        logic [32:0] r;
        @(negedge clk);
        en  = en_i;
        op  = 4'(opc);
        din = d;
        if (en_i) begin
            for (int k = 0; k < NDUT; k++) begin
                r = ref_step(m_ac[k], m_e[k], opc, {16'd0, d}, m_w[k], m_ise[k]);
                m_ac[k] = r[31:0];
                m_e[k]  = r[32];
            end
        end
        exp_q.push_back(snapshot());
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: after every edge (or async reset), compare against the queue head.
    always @(posedge clk or negedge reset_n) begin
        exp_t x;
        logic [31:0] act_ac;
        logic        act_e, act_z, act_n;
        #1;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            for (int k = 0; k < NDUT; k++) begin
                case (k)
                    0: begin act_ac = {16'd0, ac_a}; act_e = e_a; act_z = z_a; act_n = n_a; end
                    1: begin act_ac = {16'd0, ac_b}; act_e = e_b; act_z = z_b; act_n = n_b; end
                    default: begin act_ac = {24'd0, ac_c}; act_e = e_c; act_z = z_c; act_n = n_c; end
                endcase
                check($sformatf("ac[%0d]", k), act_ac, x.ac[k]);
                check($sformatf("e[%0d]", k), {31'd0, act_e}, {31'd0, x.e[k]});
                check($sformatf("zero[%0d]", k), {31'd0, act_z}, {31'd0, (x.ac[k] == 32'd0)});
                check($sformatf("neg[%0d]", k), {31'd0, act_n}, {31'd0, x.ac[k][m_w[k]-1]});
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        op      = 4'd0;
        din     = 16'd0;
        model_clear();

        // Reset state, with en/op active to show reset dominates.
        repeat (3) begin
            @(negedge clk);
            en = 1'b1;
            op = 4'd1;
            din = 16'hFFFF;
            exp_q.push_back(snapshot());
        end
        @(negedge clk);
        en = 1'b0;
        reset_n = 1'b1;

        // ADD carry-out into E, then a carry-free add clears E.
        apply(1'b1, 1, 16'hFFFF);
        apply(1'b1, 5, 16'h0000);
        apply(1'b1, 9, 16'h0001);
        apply(1'b1, 9, 16'h0001);

        // Circulate right/left through E.
        apply(1'b1, 1, 16'h8001);
        apply(1'b1, 5, 16'h0000);
        apply(1'b1, 7, 16'h0000);
        apply(1'b1, 8, 16'h0000);
        apply(1'b1, 8, 16'h0000);

        // INC wrap from all-ones.
        apply(1'b1, 1, 16'hFFFF);
        apply(1'b1, 5, 16'h0000);
        apply(1'b1, 3, 16'h0000);

        // Hold with en=0, unassigned code, complement.
        apply(1'b0, 1, 16'h1234);
        apply(1'b1, 13, 16'h5555);
        apply(1'b1, 1, 16'h00FF);
        apply(1'b1, 4, 16'h0000);

        // Narrow-width add and double complement of E.
        apply(1'b1, 1, 16'h00F0);
        apply(1'b1, 9, 16'h0020);
        apply(1'b1, 6, 16'h0000);
        apply(1'b1, 6, 16'h0000);

        // Randomized operations.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 7) != 0), int'($urandom_range(0, 15)),
                  16'($urandom));
        end

        // Reset asserted between edges right after a load.
        apply(1'b1, 1, 16'hBEEF);
        @(posedge clk);
        #2;
        model_clear();
        exp_q.push_back(snapshot());
        reset_n = 1'b0;
        @(negedge clk);
        en = 1'b1;
        op = 4'd9;
        din = 16'h7777;
        exp_q.push_back(snapshot());
        @(negedge clk);
        en = 1'b0;
        reset_n = 1'b1;

        // First enabled edge after release executes normally.
        apply(1'b1, 1, 16'hA5C3);
        apply(1'b1, 8, 16'h0000);

        // Bounded drain of outstanding expectations.
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ac_e_unit
